sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter shared by an instruction-fetch port and a MEM-stage
// load/store port. One transaction in flight at a time. Each transaction holds
// the SRAM for WAIT_CYCLES cycles and is followed by a one-cycle ready pulse.
// When both ports ask at once, the port that was not granted last wins.
//
// state  | meaning
// IDLE   | no transaction; grant a pending requester
// ACCESS | SRAM driven with latched address/data for WAIT_CYCLES cycles
// RESP   | one-cycle ready pulse to the owner, SRAM disabled
module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        mem_rd_req,
    input  logic        mem_wr_req,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_mem_q, owner_mem_d;
    logic        last_mem_q, last_mem_d;
    logic        is_wr_q, is_wr_d;
    logic        sram_en_q, sram_en_d;
    logic        sram_we_q, sram_we_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        busy_q, busy_d;

    logic        mem_any;
    logic        grant_mem;

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_mem_d  = owner_mem_q;
        last_mem_d   = last_mem_q;
        is_wr_d      = is_wr_q;
        sram_en_d    = sram_en_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        busy_d       = busy_q;

        mem_any   = mem_rd_req | mem_wr_req;
        // MEM wins if IF is absent, or on contention when IF was granted last.
        grant_mem = mem_any & (~if_req | ~last_mem_q);

        case (state_q)
            IDLE: begin
                sram_en_d = 1'b0;
                sram_we_d = 1'b0;
                busy_d    = 1'b0;
                if (if_req || mem_any) begin
                    owner_mem_d  = grant_mem;
                    last_mem_d   = grant_mem;
                    // A simultaneous read and write request is a store.
                    is_wr_d      = grant_mem & mem_wr_req;
                    sram_addr_d  = grant_mem ? mem_addr : if_addr;
                    sram_wdata_d = grant_mem ? mem_wdata : 32'h0;
                    sram_en_d    = 1'b1;
                    sram_we_d    = grant_mem & mem_wr_req;
                    cnt_d        = CNT_LOAD;
                    busy_d       = 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!is_wr_q) begin
                        if (owner_mem_q) mem_rdata_d = sram_rdata;
                        else             if_rdata_d  = sram_rdata;
                    end
                    mem_ready_d = owner_mem_q;
                    if_ready_d  = ~owner_mem_q;
                    sram_en_d   = 1'b0;
                    sram_we_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                sram_en_d = 1'b0;
                sram_we_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset clears all.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_mem_q  <= 1'b0;
            last_mem_q   <= 1'b0;
            is_wr_q      <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= 32'h0;
            sram_wdata_q <= 32'h0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            mem_rdata_q  <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_mem_q  <= owner_mem_d;
            last_mem_q   <= last_mem_d;
            is_wr_q      <= is_wr_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ready   = if_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign busy       = busy_q;

endmodule
